// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 capture front end.
//   cam_state_t : capture controller states
//   DECIM_*     : encodings of the 2-bit decim input
//   decim_shift : maps a decim code to a power-of-two shift (0, 1 or 2)
//   out_dim     : output image dimension for a given shift (dim >> shift)
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } cam_state_t;

    localparam logic [1:0] DECIM_1X  = 2'd0;
    localparam logic [1:0] DECIM_2X  = 2'd1;
    localparam logic [1:0] DECIM_4X  = 2'd2;
    localparam logic [1:0] DECIM_4XB = 2'd3;

    // Codes 2 and 3 both select 1:4 decimation.
    function automatic logic [1:0] decim_shift(input logic [1:0] code);
        logic [1:0] shift;
        case (code)
            DECIM_1X: shift = 2'd0;
            DECIM_2X: shift = 2'd1;
            default:  shift = 2'd2;
        endcase
        return shift;
    endfunction

    // Width or height of the decimated output image.
    function automatic int out_dim(input int dim, input int shift);
        return dim >> shift;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-bit 2-flop synchroniser with one extra delay stage for edge detection.
//   clk   : sampling clock
//   rst_n : synchronous active-low reset, clears all stages
//   din   : asynchronous inputs
//   lvl   : synchronised level (second stage)
//   rise  : one-cycle pulse on a 0->1 transition of lvl
//   fall  : one-cycle pulse on a 1->0 transition of lvl
module cam_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] lvl,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;
    logic [W-1:0] s3_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                    s3_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= din[gi];
                    s2_reg[gi] <= s1_reg[gi];
                    s3_reg[gi] <= s2_reg[gi];
                end
            end

            assign lvl[gi]  = s2_reg[gi];
            assign rise[gi] = s2_reg[gi] & ~s3_reg[gi];
            assign fall[gi] = ~s2_reg[gi] & s3_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670 pixel-capture controller: oversamples the camera bus in the
// CLOCK_24 domain, assembles luma (YUV422) or RGB565 pixels, decimates by
// 1/2/4 per axis and emits linear framebuffer writes.
//   CLOCK_24   : sole clock;  rst_n : synchronous active-low reset
//   D, PCLK, HREF, VSYNC : asynchronous camera pins
//   fmt_rgb    : 0 = luma, 1 = RGB565 (latched at frame start)
//   decim      : 0 = 1:1, 1 = 1:2, 2/3 = 1:4 (latched at frame start)
//   snap_mode  : 0 = continuous, 1 = capture one frame per arm pulse
//   arm        : one-cycle snapshot arm pulse
//   pix_we / pix_addr / pix_data : framebuffer write port
//   frame_done : pulse when a captured frame ends;  busy : in ACTIVE
//   ovf_err    : sticky until next frame start;  frame_cnt : completed frames
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int Y_PHASE = 0
) (
    input  logic              CLOCK_24,
    input  logic              rst_n,
    input  logic [7:0]        D,
    input  logic              PCLK,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic              fmt_rgb,
    input  logic [1:0]        decim,
    input  logic              snap_mode,
    input  logic              arm,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic              frame_done,
    output logic              busy,
    output logic              ovf_err,
    output logic [7:0]        frame_cnt
);

    // One spare bit so out-of-range columns/rows are representable; the
    // counters saturate instead of wrapping back into the valid range.
    localparam int CW = $clog2(IMG_W) + 1;
    localparam int RW = $clog2(IMG_H) + 1;
    localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
    localparam logic [RW-1:0] IMG_H_C = RW'(IMG_H);
    localparam logic          Y_BIT   = (Y_PHASE != 0);

    // ---------------- input synchronisers ----------------
    logic [2:0] ctl_lvl, ctl_rise, ctl_fall;
    logic [7:0] dat_lvl, dat_rise, dat_fall;

    cam_sync_edge #(.W(3)) u_sync_ctl (
        .clk  (CLOCK_24),
        .rst_n(rst_n),
        .din  ({PCLK, HREF, VSYNC}),
        .lvl  (ctl_lvl),
        .rise (ctl_rise),
        .fall (ctl_fall)
    );

    cam_sync_edge #(.W(8)) u_sync_dat (
        .clk  (CLOCK_24),
        .rst_n(rst_n),
        .din  (D),
        .lvl  (dat_lvl),
        .rise (dat_rise),
        .fall (dat_fall)
    );

    logic pclk_rise, href_lvl, href_rise, href_fall, vs_rise, vs_fall;
    assign pclk_rise = ctl_rise[2];
    assign href_lvl  = ctl_lvl[1];
    assign href_rise = ctl_rise[1];
    assign href_fall = ctl_fall[1];
    assign vs_rise   = ctl_rise[0];
    assign vs_fall   = ctl_fall[0];

    logic unused_sync;
    assign unused_sync = ^{ctl_lvl[2], ctl_lvl[0], ctl_fall[2], dat_rise, dat_fall};

    // ---------------- state ----------------
    cam_state_t          state_reg, state_next;
    logic                armed_reg;
    logic                fmt_reg;
    logic [1:0]          dsh_reg;
    logic [CW-1:0]       col_reg;
    logic [RW-1:0]       row_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                byte_phase_reg;
    logic [7:0]          hi_byte_reg;
    logic                pix_we_reg;
    logic [ADDR_W-1:0]   pix_addr_reg;
    logic [15:0]         pix_data_reg;
    logic                frame_done_reg;
    logic                ovf_reg;
    logic [7:0]          frame_cnt_reg;

    logic enter_active, frame_end;

    always_ff @(posedge CLOCK_24) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        enter_active = 1'b0;
        frame_end    = 1'b0;
        case (state_reg)
            IDLE: begin
                // arm on the same cycle as the VSYNC rise still counts.
                if (vs_rise && (!snap_mode || armed_reg || arm)) begin
                    state_next = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_next   = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- pixel assembly ----------------
    // A byte arriving in the same cycle as the HREF rise is treated as the
    // first byte of the new line.
    logic          phase_cur;
    logic [CW-1:0] col_cur;
    logic [CW-1:0] col_inc;
    logic [RW-1:0] row_inc;
    logic          byte_ev, pix_ev, in_bounds, on_grid;
    logic [15:0]   pix_val;
    logic [1:0]    grid_mask;

    always_comb begin
        phase_cur = href_rise ? 1'b0 : byte_phase_reg;
        col_cur   = href_rise ? '0 : col_reg;
        col_inc   = (col_cur == '1) ? col_cur : col_cur + CW'(1);
        row_inc   = (row_reg == '1) ? row_reg : row_reg + RW'(1);
        byte_ev   = (state_reg == ACTIVE) && href_lvl && pclk_rise;
        if (fmt_reg) begin
            pix_ev  = byte_ev && phase_cur;
            pix_val = {hi_byte_reg, dat_lvl};
        end else begin
            pix_ev  = byte_ev && (phase_cur == Y_BIT);
            pix_val = {8'h00, dat_lvl};
        end
        // Low d bits of the column/row must be zero for a kept pixel.
        grid_mask = {dsh_reg[1], dsh_reg[1] | dsh_reg[0]};
        in_bounds = (col_cur < IMG_W_C) && (row_reg < IMG_H_C);
        on_grid   = ((col_cur & CW'(grid_mask)) == '0) &&
                    ((row_reg & RW'(grid_mask)) == '0);
    end

    always_ff @(posedge CLOCK_24) begin
        if (!rst_n) begin
            armed_reg      <= 1'b0;
            fmt_reg        <= 1'b0;
            dsh_reg        <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            addr_reg       <= '0;
            byte_phase_reg <= 1'b0;
            hi_byte_reg    <= '0;
            pix_we_reg     <= 1'b0;
            pix_addr_reg   <= '0;
            pix_data_reg   <= '0;
            frame_done_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            pix_we_reg     <= 1'b0;
            frame_done_reg <= frame_end;

            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                armed_reg     <= 1'b0;
            end else if (arm && state_reg != ACTIVE) begin
                armed_reg <= 1'b1;
            end

            if (enter_active) begin
                fmt_reg        <= fmt_rgb;
                dsh_reg        <= decim_shift(decim);
                col_reg        <= '0;
                row_reg        <= '0;
                addr_reg       <= '0;
                byte_phase_reg <= 1'b0;
                ovf_reg        <= 1'b0;
            end else if (state_reg == ACTIVE) begin
                if (href_rise) begin
                    col_reg        <= '0;
                    byte_phase_reg <= 1'b0;
                end
                if (byte_ev) begin
                    byte_phase_reg <= ~phase_cur;
                    if (!phase_cur) begin
                        hi_byte_reg <= dat_lvl;
                    end
                end
                if (pix_ev) begin
                    col_reg <= col_inc;
                    if (!in_bounds) begin
                        ovf_reg <= 1'b1;
                    end else if (on_grid) begin
                        pix_we_reg   <= 1'b1;
                        pix_addr_reg <= addr_reg;
                        pix_data_reg <= pix_val;
                        addr_reg     <= addr_reg + ADDR_W'(1);
                    end
                end
                // Lines that delivered no pixel do not advance the row.
                if (href_fall && col_reg != '0) begin
                    row_reg <= row_inc;
                end
            end
        end
    end

    assign pix_we     = pix_we_reg;
    assign pix_addr   = pix_addr_reg;
    assign pix_data   = pix_data_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg == ACTIVE);
    assign ovf_err    = ovf_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int ADDR_W  = 5;
    localparam int Y_PHASE = 0;

    logic              CLOCK_24 = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        D        = '0;
    logic              PCLK     = 1'b0;
    logic              HREF     = 1'b0;
    logic              VSYNC    = 1'b0;
    logic              fmt_rgb  = 1'b0;
    logic [1:0]        decim    = '0;
    logic              snap_mode = 1'b0;
    logic              arm      = 1'b0;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [15:0]       pix_data;
    logic              frame_done;
    logic              busy;
    logic              ovf_err;
    logic [7:0]        frame_cnt;

    cam_capture_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .Y_PHASE(Y_PHASE)
    ) dut (
        .CLOCK_24  (CLOCK_24),
        .rst_n     (rst_n),
        .D         (D),
        .PCLK      (PCLK),
        .HREF      (HREF),
        .VSYNC     (VSYNC),
        .fmt_rgb   (fmt_rgb),
        .decim     (decim),
        .snap_mode (snap_mode),
        .arm       (arm),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .frame_done(frame_done),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .frame_cnt (frame_cnt)
    );

    always #5 CLOCK_24 = ~CLOCK_24;

    int cyc = 0;
    always @(posedge CLOCK_24) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected writes: address, data and the cycle the completing PCLK rise was driven.
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_cyc[$];

    // Log of observed writes since the current scenario began.
    int          got_n = 0;
    int          got_addr[64];
    logic [15:0] got_data[64];
    int          done_seen = 0;

    // Frame-level model of the capture rules.
    bit m_capturing = 0;   // a frame is being written
    bit m_pending   = 0;   // capture starts at the next end of vertical blank
    bit m_armed     = 0;
    bit m_fmt       = 0;
    bit m_ovf       = 0;
    int m_step      = 1;
    int m_addr      = 0;
    int m_row       = 0;
    int m_frames    = 0;
    int m_done      = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_24);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    task automatic compare_loop();
        int ea, ec;
        logic [15:0] ed;
        forever begin
            @(negedge CLOCK_24);
            if (frame_done === 1'b1) done_seen++;
            if (pix_we === 1'b1) begin
                $display("write addr=%0d data=%h cyc=%0d", pix_addr, pix_data, cyc);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", {27'd0, pix_addr}, 32'hFFFF_FFFF);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    ec = exp_cyc.pop_front();
                    check("wr_addr", {27'd0, pix_addr}, ea);
                    check("wr_data", {16'd0, pix_data}, {16'd0, ed});
                    check("wr_latency", cyc - ec, 3);
                end
                if (got_n < 64) begin
                    got_addr[got_n] = int'(pix_addr);
                    got_data[got_n] = pix_data;
                end
                got_n++;
            end
        end
    endtask

    function automatic logic [7:0] gen(input int pat, input int r, input int idx);
        if (pat == 0) return 8'(16 + r * 16 + idx);
        if (idx % 2 == 0) return 8'(8'hA1 + r * 8 + idx / 2);
        return 8'(8'hB2 + r * 8 + idx / 2);
    endfunction

    task automatic vsync_pulse();
        VSYNC = 1'b1;
        if (m_capturing) begin
            m_capturing = 0;
            m_frames++;
            m_done++;
            m_armed = 0;
        end else if (!snap_mode || m_armed) begin
            m_pending = 1;
        end
        tick(6);
        VSYNC = 1'b0;
        if (m_pending) begin
            m_pending   = 0;
            m_capturing = 1;
            m_fmt       = fmt_rgb;
            m_step      = (decim == 2'd0) ? 1 : (decim == 2'd1) ? 2 : 4;
            m_addr      = 0;
            m_row       = 0;
            m_ovf       = 0;
        end
        tick(6);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        if (!m_capturing) m_armed = 1;
        tick(1);
        arm = 1'b0;
        tick(2);
    endtask

    task automatic do_reset_mid();
        rst_n = 1'b0;
        PCLK  = 1'b0;
        m_capturing = 0; m_pending = 0; m_armed = 0; m_frames = 0; m_ovf = 0;
        tick(3);
        check("rst_pix_we", {31'd0, pix_we}, 0);
        check("rst_pix_addr", {27'd0, pix_addr}, 0);
        check("rst_pix_data", {16'd0, pix_data}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ovf_err", {31'd0, ovf_err}, 0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
        check("rst_pending_writes", exp_addr.size(), 0);
        rst_n = 1'b1;
        tick(2);
    endtask

    // One frame: blanking pulse, then nlines lines of nbytes bytes each.
    task automatic run_frame(input int nlines, input int nbytes, input int pat,
                             input int rst_line, input int rst_idx, input bit arm_mid);
        logic [7:0] b, prev;
        int col;
        bit pix;
        logic [15:0] val;
        vsync_pulse();
        for (int r = 0; r < nlines; r++) begin
            if (arm_mid && r == 1) pulse_arm();
            HREF = 1'b1;
            tick(3);
            check("busy_in_line", {31'd0, busy}, {31'd0, m_capturing});
            prev = '0;
            for (int idx = 0; idx < nbytes; idx++) begin
                b    = gen(pat, r, idx);
                D    = b;
                PCLK = 1'b0;
                tick(2);
                PCLK = 1'b1;
                pix  = 0;
                col  = idx / 2;
                val  = '0;
                if (m_capturing) begin
                    if (!m_fmt && (idx % 2) == Y_PHASE) begin
                        pix = 1; val = {8'h00, b};
                    end else if (m_fmt && (idx % 2) == 1) begin
                        pix = 1; val = {prev, b};
                    end
                end
                if (pix) begin
                    if (col >= IMG_W || m_row >= IMG_H) m_ovf = 1;
                    else if (col % m_step == 0 && m_row % m_step == 0) begin
                        exp_addr.push_back(m_addr);
                        exp_data.push_back(val);
                        exp_cyc.push_back(cyc);
                        m_addr++;
                    end
                end
                prev = b;
                tick(2);
                if (r == rst_line && idx == rst_idx) do_reset_mid();
            end
            PCLK = 1'b0;
            HREF = 1'b0;
            if (m_capturing) m_row++;
            tick(4);
        end
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_queue_empty"}, exp_addr.size(), 0);
        check({tag, "_frame_cnt"}, {24'd0, frame_cnt}, m_frames);
        check({tag, "_frame_done"}, done_seen, m_done);
        check({tag, "_ovf_err"}, {31'd0, ovf_err}, {31'd0, m_ovf});
        check({tag, "_busy_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            compare_loop();
        join_none

        // Reset state.
        tick(4);
        check("reset_pix_we", {31'd0, pix_we}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_frame_cnt", {24'd0, frame_cnt}, 0);
        check("reset_ovf_err", {31'd0, ovf_err}, 0);
        check("reset_frame_done", {31'd0, frame_done}, 0);
        rst_n = 1'b1;
        tick(4);

        // Luma, continuous, 1:1.
        $display("scenario luma_1x");
        got_n = 0;
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("luma");
        check("luma_writes", got_n, 32);
        check("luma_addr31", got_addr[31], 31);
        check("luma_data5", {16'd0, got_data[5]}, 32'h001A);
        check("luma_data31", {16'd0, got_data[31]}, 32'h004E);
        check("luma_frame_cnt_lit", {24'd0, frame_cnt}, 1);
        check("luma_done_lit", done_seen, 1);

        // RGB565, 1:1.
        $display("scenario rgb_1x");
        fmt_rgb = 1'b1;
        got_n = 0;
        run_frame(4, 16, 1, -1, -1, 0);
        vsync_pulse();
        end_scenario("rgb");
        check("rgb_writes", got_n, 32);
        check("rgb_addr0", got_addr[0], 0);
        check("rgb_data0", {16'd0, got_data[0]}, 32'hA1B2);

        // Luma, 1:2.
        $display("scenario luma_2x");
        fmt_rgb = 1'b0;
        decim   = 2'd1;
        got_n = 0;
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("dec2");
        check("dec2_writes", got_n, 8);
        check("dec2_data1", {16'd0, got_data[1]}, 32'h0014);
        check("dec2_data4", {16'd0, got_data[4]}, 32'h0030);
        check("dec2_addr7", got_addr[7], 7);

        // Snapshot: nothing without arm, one frame after arm, mid-frame arm ignored.
        $display("scenario snapshot");
        decim     = 2'd0;
        snap_mode = 1'b1;
        got_n = 0;
        run_frame(4, 16, 0, -1, -1, 0);
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("snap_noarm");
        check("snap_noarm_writes", got_n, 0);
        pulse_arm();
        run_frame(4, 16, 0, -1, -1, 1);
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("snap_arm");
        check("snap_arm_writes", got_n, 32);

        // Overrun: 10-pixel lines, then a clean frame.
        $display("scenario overrun");
        snap_mode = 1'b0;
        got_n = 0;
        run_frame(4, 20, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("ovf");
        check("ovf_writes", got_n, 32);
        check("ovf_flag_lit", {31'd0, ovf_err}, 1);
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("ovf_clear");
        check("ovf_cleared_lit", {31'd0, ovf_err}, 0);

        // Reset mid-line, then a full frame from address 0.
        $display("scenario reset_mid_line");
        got_n = 0;
        run_frame(4, 16, 0, 1, 5, 0);
        check("rst_partial_writes", got_n, 11);
        run_frame(4, 16, 0, -1, -1, 0);
        vsync_pulse();
        end_scenario("rst");
        check("rst_total_writes", got_n, 43);
        check("rst_next_addr0", got_addr[11], 0);
        check("rst_next_data0", {16'd0, got_data[11]}, 32'h0010);
        check("rst_frame_cnt_lit", {24'd0, frame_cnt}, 1);

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
